serial_sub_unit: RTL
====================

# serial_sub_unit

Bit-serial ripple-borrow subtractor for the arithmetic datapath. Complements the parallel adder: it computes `a - b - bin` one bit per clock using a single full-subtractor cell, so it trades latency for area. Operands enter on a valid/ready handshake. The result is held on a valid/ready output until it is consumed.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands and borrow-in are valid this cycle.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result is valid and held.
- `out_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  difference.
- `bout`  out  1  borrow-out from the MSB.
- `ovf`  out  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- The FSM has three states:
  - IDLE: `in_ready`=1.
  - RUN: bit counter 0..WIDTH-1.
  - HOLD: `out_valid`=1.
- IDLE to RUN when `in_valid` && `in_ready` at a rising edge.
  - `a`, `b` and `bin` are captured into internal shift registers.
  - The borrow register is loaded with `bin` and the counter is cleared.
  - Input changes after capture are ignored.
- RUN, per cycle, on bit i = counter:
  - d = a[i]^b[i]^br.
  - br' = (~a[i]&b[i]) | (~(a[i]^b[i])&br).
  - d is shifted into `diff` from the MSB side, so after WIDTH shifts bit i lands at `diff[i]`.
  - The counter increments. At counter == WIDTH-1 the FSM goes to HOLD and `bout` takes the final br'.
- HOLD: `diff`, `bout` and `ovf` are stable. On `out_valid` && `out_ready` the FSM goes to IDLE.
- Arithmetic: `diff` = (a - b - bin) mod 2^WIDTH. `bout` = 1 iff the unsigned value a < b + bin.
- `in_ready` = (state == IDLE) only. There is no same-cycle accept from HOLD and no overlap of operations.
- `in_valid` in RUN or HOLD is ignored; the upstream must hold its data until `in_ready`.
- Reset values: `in_ready`=1, `out_valid`=0, `diff`=0, `bout`=0, `ovf`=0. The FSM is in IDLE and the counter is 0.
- Reset mid-operation (RUN or HOLD): the operation is abandoned, nothing is emitted, and all outputs return to their reset values immediately (asynchronous).
- `diff`, `bout` and `ovf` are registered. Outside HOLD they show partial values and are not meaningful.

## Timing
- Accept at edge E0. Bits are computed at edges E1..E_WIDTH.
- `out_valid` rises after E_WIDTH. Latency is WIDTH cycles from accept to `out_valid`; for WIDTH=8 that is 8 cycles.
- `out_valid` stays high until the handshake edge. `in_ready` rises on the cycle after the handshake.
- Best-case throughput: one operation per WIDTH+2 cycles (accept, WIDTH RUN cycles, 1-cycle HOLD).
- No combinational path from inputs to outputs.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - `ovf` port exists.
  - `ovf` = borrow into the MSB XOR borrow out of the MSB (signed overflow of a - b - bin).
  - Valid in HOLD; reset value 0.
- `SERIAL_SUB_OVF_EN` undefined: no `ovf` port and no MSB-borrow tracking register.

## Test plan
- a=8'h3C, b=8'h1A, bin=0, `out_ready`=1 -> after 8 cycles `diff`=8'h22, `bout`=0; `in_ready` high 2 cycles after accept completes.
- a=8'h00, b=8'h01, bin=0 -> `diff`=8'hFF, `bout`=1.
- a=8'h55, b=8'h55, bin=1 -> `diff`=8'hFF, `bout`=1.
- With `SERIAL_SUB_OVF_EN`: a=8'h80, b=8'h01, bin=0 -> `diff`=8'h7F, `ovf`=1, `bout`=0.
- Back-pressure: hold `out_ready`=0 for 5 cycles in HOLD -> `out_valid` and `diff` stable; `in_valid` with new operands is ignored until `in_ready`=1.
- Assert `rst_n`=0 at RUN bit 4 -> outputs at reset values immediately; after release, the next operation 8'h10-8'h01 yields 8'h0F.

Source files
------------

// File: rtl/serial_sub_unit.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_unit
// Description : Bit-serial ripple-borrow subtractor, diff = a - b - bin.
//               One full-subtractor cell is used once per clock, LSB first.
//               Optional signed-overflow output: define SERIAL_SUB_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_br;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_in_ready;
   logic             r_out_valid;
`ifdef SERIAL_SUB_OVF_EN
   logic             r_ovf;
`endif

   logic w_ai;
   logic w_bi;
   logic w_d;
   logic w_br_nxt;
   logic w_last;

   // Operands shift right so the current bit is always at position 0.
   assign w_ai     = r_a[0];
   assign w_bi     = r_b[0];
   assign w_d      = w_ai ^ w_bi ^ r_br;
   assign w_br_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_br        <= 1'b0;
         r_cnt       <= '0;
         r_diff      <= '0;
         r_bout      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_br       <= bin;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               r_a    <= r_a >> 1;
               r_b    <= r_b >> 1;
               r_br   <= w_br_nxt;
               r_diff <= {w_d, r_diff[WIDTH-1:1]};
               r_cnt  <= r_cnt + CW'(1);
               if (w_last) begin
                  r_bout      <= w_br_nxt;
                  r_out_valid <= 1'b1;
                  r_state     <= S_HOLD;
`ifdef SERIAL_SUB_OVF_EN
                  // r_br still holds the borrow into the MSB here.
                  r_ovf       <= r_br ^ w_br_nxt;
`endif
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign diff      = r_diff;
   assign bout      = r_bout;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf       = r_ovf;
`endif

endmodule
`default_nettype wire
